icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the fetch stage and the memory controller. Hits return the instruction word in the same cycle and assert `ihit`, which the hazard unit uses to advance the pipeline. Misses stall fetch (`ihit` low) while a one-word block is fetched over the `iREN`/`iwait` handshake and written into the frame.

## Interface
Parameters:
- `NSETS`, 16: number of frames (power of two); index width `IDXW = log2(NSETS)` = 4.
- `TAGW`, 26: tag width, equal to 32 − `IDXW` − 2.

Ports:
- `CLK`  in  1  the single clock.
- `RST`  in  1  synchronous, active-high reset.
- `imemREN`  in  1  fetch stage requests an instruction.
- `imemaddr`  in  32  byte address; [1:0] byte offset (ignored), [IDXW+1:2] index, [31:IDXW+2] tag.
- `ihit`  out  1  `imemload` is valid this cycle; consumed by the hazard unit.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  read request to the memory controller.
- `iaddr`  out  32  word-aligned miss address to the memory controller.
- `iwait`  in  1  memory busy; the fill completes in the first cycle `iREN` is high and `iwait` is low.
- `iload`  in  32  memory read data, valid when `iwait` is low.

One clock, `CLK`. Reset `RST` is synchronous and active-high.

## Operation
- Storage per frame: `valid` (1), `tag` (TAGW), `data` (32).
- FSM has two states: COMPARE (reset state) and FETCH.
- COMPARE:
  - hit = `imemREN` & `valid[idx]` & (`tag[idx]` == addr tag).
  - On hit: `ihit`=1 and `imemload`=`data[idx]`, both combinational.
  - On `imemREN` & !hit: latch `{addr[31:2],2'b00}` into the miss register and go to FETCH.
  - If `imemREN`=0: stay in COMPARE, `ihit`=0.
- FETCH:
  - `iREN`=1, `iaddr`=miss register, `ihit`=0.
  - If `iwait`=1: stay in FETCH.
  - If `iwait`=0: write the frame at the latched index: `valid`=1, `tag`=latched tag, `data`=`iload`. Then go to COMPARE.
- No bypass: the fill cycle does not assert `ihit`. The following COMPARE cycle hits if fetch is still requesting the same address.
- `imemload`=0 whenever `ihit`=0.
- A fill overwrites the frame unconditionally. There is no dirty state and no writeback.

## Timing
- Hit latency is 0 cycles: `ihit` is asserted in the same cycle as the request.
- Miss: cycle 0 COMPARE detects the miss; FETCH runs for cycles 1..1+W, where W = number of `iwait`-high cycles; cycle 2+W is COMPARE with a hit. Total stall is 2+W cycles.
- Reset values:
  - `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
  - All `valid`=0. State is COMPARE, miss register is 0.
- Boundary cases:
  - `RST` asserted during FETCH: at that edge the FSM goes to COMPARE, `iREN` drops in the next cycle, all frames are invalidated, and no fill is written, even if `iwait` was 0 that cycle.
  - `imemREN` drops or `imemaddr` changes during FETCH: the fetch still completes to the latched address and the fill is written. The new address is compared only after return to COMPARE.
  - Conflict miss on the same index with a different tag: the old frame is replaced and a later access to the old tag misses again.
  - Byte-offset bits never affect hit/miss, and `iaddr`[1:0] is always 0.
  - `iwait` is ignored in COMPARE.

## Test plan
- Cold miss: after reset, `imemREN`=1, `imemaddr`=0x0000_0040, `iwait` high for 3 cycles, then low with `iload`=0x2001_0005. Required: `iREN`=1 and `iaddr`=0x40 for 4 cycles, then `ihit`=1 with `imemload`=0x2001_0005 in the next cycle. Total stall is 5 cycles.
- Hit after fill: repeat 0x40, then 0x42. Required: `ihit`=1 in the same cycle for both, `iREN`=0, data 0x2001_0005.
- Conflict: fill 0x40, then 0x0000_1040 (same index 0, different tag) with `iload`=0xAAAA_0001. Required: miss, then refill. Returning to 0x40 misses again and `iaddr`=0x40.
- Address change mid-fetch: miss on 0x80, then switch `imemaddr` to 0xC0 while `iwait`=1. Required: `iaddr` stays 0x80 and frame 0 index 0 is filled with tag of 0x80. Then 0xC0 misses and is fetched separately.
- Reset during FETCH: miss on 0x40, assert `RST` in the cycle `iwait` goes low. Required: `iREN`=0 afterwards, and a re-access of 0x40 misses (frame not written).
- Sweep all 16 indices: fill 0x000–0x03C. Required: each hits on re-read, and 0 `iREN` cycles occur during the second pass.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word blocks.
// A hit returns the instruction word combinationally in the request cycle.
// A miss stalls fetch while the word is read from memory over iREN/iwait.
// The word is then written into the frame, and the next COMPARE cycle hits.
//
// Handshake: a memory read is in flight whenever iREN is high. iaddr holds
// steady for the whole transfer. The transfer completes in the first cycle
// that iREN is high and iwait is low. iload is sampled in that cycle only.
module icache #(
    parameter int NSETS = 16,
    parameter int IDXW  = $clog2(NSETS),
    parameter int TAGW  = 32 - IDXW - 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        dbg_state_o
);

    typedef enum logic {
        COMPARE = 1'b0,
        FETCH   = 1'b1
    } state_e;

    state_e            state_q;
    logic              iren_q;
    logic [31:0]       miss_q;

    logic [NSETS-1:0]  valid_q;
    logic [TAGW-1:0]   tag_q  [NSETS];
    logic [31:0]       data_q [NSETS];

    logic [IDXW-1:0]   req_idx;
    logic [TAGW-1:0]   req_tag;
    logic [IDXW-1:0]   miss_idx;
    logic [TAGW-1:0]   miss_tag;
    logic              frame_match;
    logic              fill_en;
    logic              unused_offset;

    // Split the request and the latched miss address into index and tag.
    assign req_idx  = imemaddr[IDXW+1:2];
    assign req_tag  = imemaddr[31:IDXW+2];
    assign miss_idx = miss_q[IDXW+1:2];
    assign miss_tag = miss_q[31:IDXW+2];

    // The byte offset never takes part in the lookup.
    assign unused_offset = ^imemaddr[1:0];

    // The frame at the request index holds the requested word.
    assign frame_match = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // A hit is only reported from COMPARE. The fill cycle does not bypass iload.
    assign ihit     = (state_q == COMPARE) && imemREN && frame_match;
    assign imemload = ihit ? data_q[req_idx] : 32'h0000_0000;

    // Memory side: the request and address both come straight from registers.
    assign iREN  = iren_q;
    assign iaddr = miss_q;

    // A fill lands on the first FETCH cycle with memory ready.
    // A reset in that same cycle cancels the fill.
    assign fill_en = (state_q == FETCH) && !iwait && !RST;

    assign dbg_state_o = state_q;

    // Miss-handling FSM. The memory request and the miss address are registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= COMPARE;
            iren_q  <= 1'b0;
            miss_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                COMPARE: begin
                    if (imemREN && !frame_match) begin
                        miss_q  <= {imemaddr[31:2], 2'b00};
                        iren_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        iren_q  <= 1'b0;
                        state_q <= COMPARE;
                    end
                end
                default: begin
                    iren_q  <= 1'b0;
                    state_q <= COMPARE;
                end
            endcase
        end
    end

    // Valid bits. Reset invalidates every frame, and a fill validates its frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[miss_idx] <= 1'b1;
        end
    end

    // Tag and data arrays. A fill unconditionally overwrites the latched frame.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Testbench for icache. It has three parts:
// - a per-cycle vector table for the directed corner cases
// - an index sweep
// - randomized accesses checked against a map from each index to the resident word address
module tb_icache;

  logic        clk;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        ihit;
  logic [31:0] imem_load;
  logic        i_ren;
  logic [31:0] i_addr;
  logic        i_wait;
  logic [31:0] i_load;
  logic        dbg_state;

  int n_vec;
  int n_bad;

  icache dut (
    .CLK         (clk),
    .RST         (rst),
    .imemREN     (imem_ren),
    .imemaddr    (imem_addr),
    .ihit        (ihit),
    .imemload    (imem_load),
    .iREN        (i_ren),
    .iaddr       (i_addr),
    .iwait       (i_wait),
    .iload       (i_load),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // each entry gives one cycle: the inputs driven, then the outputs expected before the edge
  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t tbl_q[$];

  // reference model: which word address each index holds, and a backing memory
  bit          m_v    [16];
  logic [29:0] m_word [16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return w * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_v[a[5:2]] && (m_word[a[5:2]] == a[31:2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic ren, input logic [31:0] a, input logic iw,
                     input logic [31:0] ld, input logic eh, input logic [31:0] el,
                     input logic er, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.ren = ren; v.addr = a; v.iw = iw; v.ld = ld;
    v.e_hit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea;
    tbl_q.push_back(v);
  endtask

  // driver: inputs are set #1 after a rising edge; settle_and_next samples at mid-cycle, then moves on
  task automatic settle();
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ren = 1'b0; i_wait = 1'b0;
    next_cycle();
    rst = 1'b0;
    model_clear();
  endtask

  // One fetch access. If it misses, fetch sees W random wait cycles and the fill, then a hit.
  task automatic do_access(input logic [31:0] a, input string tagname);
    int w;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    imem_ren = 1'b1; imem_addr = a; i_wait = 1'($urandom_range(0, 1)); i_load = $urandom;
    settle();
    if (model_hit(a)) begin
      chk({tagname, " hit ihit"}, {31'b0, ihit}, 32'd1);
      chk({tagname, " hit data"}, imem_load, mem_word(a));
      chk({tagname, " hit iREN"}, {31'b0, i_ren}, 32'd0);
      next_cycle();
    end else begin
      chk({tagname, " miss ihit"}, {31'b0, ihit}, 32'd0);
      chk({tagname, " miss load"}, imem_load, 32'd0);
      chk({tagname, " miss iREN"}, {31'b0, i_ren}, 32'd0);
      next_cycle();
      w = $urandom_range(0, 3);
      for (int k = 0; k <= w; k++) begin
        i_wait = (k < w);
        i_load = (k < w) ? $urandom : mem_word(a);
        // fetch may wander while stalled; the transfer must not follow it
        imem_ren = 1'($urandom_range(0, 1));
        imem_addr = $urandom;
        settle();
        chk({tagname, " fetch iREN"}, {31'b0, i_ren}, 32'd1);
        chk({tagname, " fetch iaddr"}, i_addr, wa);
        chk({tagname, " fetch ihit"}, {31'b0, ihit}, 32'd0);
        next_cycle();
      end
      m_v[a[5:2]] = 1'b1;
      m_word[a[5:2]] = a[31:2];
      imem_ren = 1'b1; imem_addr = a; i_wait = 1'($urandom_range(0, 1));
      settle();
      chk({tagname, " refill ihit"}, {31'b0, ihit}, 32'd1);
      chk({tagname, " refill data"}, imem_load, mem_word(a));
      chk({tagname, " refill iREN"}, {31'b0, i_ren}, 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    int iren_cycles;
    logic [31:0] a;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; imem_ren = 1'b0; imem_addr = 32'h0; i_wait = 1'b0; i_load = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // directed table:      rst ren addr         iw  iload          hit load           iren iaddr
    add(1, 0, 32'h0000_0000, 0, 32'h0,         0, 32'h0,         0, 32'h0);    // reset state
    add(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0);    // cold miss, iwait ignored
    add(0, 1, 32'h0000_0040, 1, 32'hDEAD_0000, 0, 32'h0,         1, 32'h40);
    add(0, 1, 32'h0000_0040, 1, 32'hDEAD_0000, 0, 32'h0,         1, 32'h40);
    add(0, 1, 32'h0000_0040, 1, 32'hDEAD_0000, 0, 32'h0,         1, 32'h40);
    add(0, 1, 32'h0000_0040, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h40);   // fill, no bypass
    add(0, 1, 32'h0000_0040, 0, 32'h0,         1, 32'h2001_0005, 0, 32'h40);   // hit after fill
    add(0, 1, 32'h0000_0042, 1, 32'h0,         1, 32'h2001_0005, 0, 32'h40);   // byte offset hit
    add(0, 1, 32'h0000_1040, 0, 32'hAAAA_0001, 0, 32'h0,         0, 32'h40);   // conflict miss
    add(0, 1, 32'h0000_1040, 0, 32'hAAAA_0001, 0, 32'h0,         1, 32'h1040);
    add(0, 1, 32'h0000_1040, 0, 32'h0,         1, 32'hAAAA_0001, 0, 32'h1040);
    add(0, 1, 32'h0000_0040, 0, 32'h0,         0, 32'h0,         0, 32'h1040); // old tag misses
    add(0, 1, 32'h0000_0040, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h40);
    add(0, 1, 32'h0000_0040, 0, 32'h0,         1, 32'h2001_0005, 0, 32'h40);
    add(0, 0, 32'h0000_0040, 0, 32'h0,         0, 32'h0,         0, 32'h40);   // idle
    add(0, 1, 32'h0000_0080, 1, 32'h0,         0, 32'h0,         0, 32'h40);   // miss on 0x80
    add(0, 1, 32'h0000_00C0, 1, 32'h0,         0, 32'h0,         1, 32'h80);   // addr changes
    add(0, 0, 32'h0000_00C0, 0, 32'h1111_0080, 0, 32'h0,         1, 32'h80);   // ren drops, fill
    add(0, 1, 32'h0000_0080, 0, 32'h0,         1, 32'h1111_0080, 0, 32'h80);   // filled with 0x80
    add(0, 1, 32'h0000_00C0, 0, 32'h0,         0, 32'h0,         0, 32'h80);   // 0xC0 misses
    add(0, 1, 32'h0000_00C0, 0, 32'h1111_00C0, 0, 32'h0,         1, 32'hC0);
    add(0, 1, 32'h0000_00C0, 0, 32'h0,         1, 32'h1111_00C0, 0, 32'hC0);
    add(0, 1, 32'h0000_0040, 0, 32'h0,         0, 32'h0,         0, 32'hC0);   // miss
    add(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h40);
    add(1, 1, 32'h0000_0040, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h40);   // reset on fill
    add(0, 1, 32'h0000_0040, 0, 32'h0,         0, 32'h0,         0, 32'h0);    // not written
    add(0, 1, 32'h0000_0040, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h40);
    add(0, 1, 32'h0000_0043, 0, 32'h0,         1, 32'h2001_0005, 0, 32'h40);
    add(0, 0, 32'h0000_0040, 0, 32'h0,         0, 32'h0,         0, 32'h40);

    foreach (tbl_q[i]) begin
      rst = tbl_q[i].rst; imem_ren = tbl_q[i].ren; imem_addr = tbl_q[i].addr;
      i_wait = tbl_q[i].iw; i_load = tbl_q[i].ld;
      settle();
      chk($sformatf("tbl[%0d] ihit", i), {31'b0, ihit}, {31'b0, tbl_q[i].e_hit});
      chk($sformatf("tbl[%0d] imemload", i), imem_load, tbl_q[i].e_load);
      chk($sformatf("tbl[%0d] iREN", i), {31'b0, i_ren}, {31'b0, tbl_q[i].e_iren});
      chk($sformatf("tbl[%0d] iaddr", i), i_addr, tbl_q[i].e_iaddr);
      next_cycle();
    end

    // sweep all 16 indices, then re-read them with no memory traffic allowed
    do_reset();
    for (int i = 0; i < 16; i++) do_access(32'(i * 4), "sweep1");
    iren_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      imem_ren = 1'b1; imem_addr = 32'(i * 4); i_wait = 1'b0;
      settle();
      chk("sweep2 ihit", {31'b0, ihit}, 32'd1);
      chk("sweep2 data", imem_load, mem_word(32'(i * 4)));
      if (i_ren) iren_cycles++;
      next_cycle();
    end
    chk("sweep2 iREN cycles", 32'(iren_cycles), 32'd0);

    // randomized accesses against the reference model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        imem_ren = 1'b0; imem_addr = $urandom; i_wait = 1'($urandom_range(0, 1));
        settle();
        chk("idle ihit", {31'b0, ihit}, 32'd0);
        chk("idle load", imem_load, 32'd0);
        chk("idle iREN", {31'b0, i_ren}, 32'd0);
        next_cycle();
      end
      a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      do_access(a, "rand");
      chk("rand iaddr low bits", {30'b0, i_addr[1:0]}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
